// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- Instruction Fetch stage of the XUM MIPS32 pipeline.
// Owns the program counter, runs the request/ready handshake to instruction
// memory and offers one instruction at a time to the IF/ID register.
// Optional build macro: IF_FETCH_BYPASS_EN -- when defined, a returning word is
// offered in its own Ready cycle, so zero-wait memory sustains one fetch per
// cycle. When undefined, every word is first registered into the hold register.

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_Stall,
  input  logic        ID_IsBranch,
  input  logic        PC_Redirect,
  input  logic [31:0] Redirect_Target,
  input  logic        Exc_Redirect,
  input  logic [31:0] Exc_Target,
  output logic        InstMem_Read,
  output logic [29:0] InstMem_Address,
  input  logic        InstMem_Ready,
  input  logic [31:0] InstMem_In,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_IsBDS,
  output logic        IF_Stall
);

  // BOOT: idle after reset; REQ: request outstanding; HOLD: word captured and
  // waiting for ID; DISCARD: request outstanding whose data must be dropped.
  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  // The two low PC bits are never meaningful for word fetches.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_t r_state;
  fetch_state_t w_stateNext;

  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic        r_pending;
  logic        w_pendingNext;
  logic [31:0] r_pendTarget;
  logic [31:0] w_pendTargetNext;
  logic        r_excSeen;
  logic        w_excSeenNext;
  logic [31:0] r_holdInstr;
  logic [31:0] w_holdInstrNext;
  logic [29:0] r_reqAddr;
  logic        w_newRequest;

  logic        w_bypassHit;
  logic        w_offer;
  logic [31:0] w_offerInstr;
  logic        w_handoff;
  logic [31:0] w_pcPlus4;
  logic        w_redirPending;
  logic [31:0] w_redirTarget;
  logic [31:0] w_excPc;

`ifdef IF_FETCH_BYPASS_EN
  assign w_bypassHit = (r_state == ST_REQ) && InstMem_Ready;
`else
  assign w_bypassHit = 1'b0;
`endif

  // An instruction is offered from the hold register, or straight from memory
  // in bypass builds; an exception in the same cycle suppresses any offer.
  assign w_offer      = !Exc_Redirect && ((r_state == ST_HOLD) || w_bypassHit);
  assign w_offerInstr = (r_state == ST_HOLD) ? r_holdInstr : InstMem_In;
  assign w_handoff    = w_offer && !ID_Stall;
  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_excPc      = Exc_Target & 32'hFFFF_FFFC;

  // A redirect arriving in the very cycle its delay slot is handed off must
  // still steer the next fetch, so the live request is merged with the
  // remembered one before choosing the next PC.
  assign w_redirPending = r_pending || PC_Redirect;
  assign w_redirTarget  = PC_Redirect ? Redirect_Target : r_pendTarget;

  // Next-state logic: exceptions win outright, otherwise redirect bookkeeping,
  // handoff PC advance and the per-state handshake progression.
  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_pendingNext    = r_pending;
    w_pendTargetNext = r_pendTarget;
    w_excSeenNext    = r_excSeen;
    w_holdInstrNext  = r_holdInstr;
    w_newRequest     = 1'b0;

    if (Exc_Redirect) begin
      w_pcNext        = w_excPc;
      w_pendingNext   = 1'b0;
      w_excSeenNext   = 1'b1;
      w_holdInstrNext = 32'd0;
      if (((r_state == ST_REQ) || (r_state == ST_DISCARD)) && !InstMem_Ready) begin
        w_stateNext = ST_DISCARD;
      end else begin
        w_stateNext  = ST_REQ;
        w_newRequest = 1'b1;
      end
    end else begin
      if (PC_Redirect) begin
        w_pendingNext    = 1'b1;
        w_pendTargetNext = Redirect_Target;
      end

      if (w_handoff) begin
        w_pcNext      = w_redirPending ? w_redirTarget : w_pcPlus4;
        w_pendingNext = 1'b0;
        w_excSeenNext = 1'b0;
      end

      case (r_state)
        ST_BOOT: begin
          w_stateNext  = ST_REQ;
          w_newRequest = 1'b1;
        end
        ST_REQ: begin
          if (InstMem_Ready) begin
            if (w_handoff) begin
              w_stateNext  = ST_REQ;
              w_newRequest = 1'b1;
            end else begin
              w_holdInstrNext = InstMem_In;
              w_stateNext     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_handoff) begin
            w_stateNext  = ST_REQ;
            w_newRequest = 1'b1;
          end
        end
        ST_DISCARD: begin
          if (InstMem_Ready) begin
            w_stateNext  = ST_REQ;
            w_newRequest = 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_BOOT;
        end
      endcase
    end
  end

  // State and datapath registers; an abandoned request keeps its address so
  // the memory sees a stable address until its single Ready comes back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC_ALIGNED;
      r_pending    <= 1'b0;
      r_pendTarget <= 32'd0;
      r_excSeen    <= 1'b0;
      r_holdInstr  <= 32'd0;
      r_reqAddr    <= RESET_PC_ALIGNED[31:2];
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_pending    <= w_pendingNext;
      r_pendTarget <= w_pendTargetNext;
      r_excSeen    <= w_excSeenNext;
      r_holdInstr  <= w_holdInstrNext;
      if (w_newRequest) begin
        r_reqAddr <= w_pcNext[31:2];
      end
    end
  end

  assign InstMem_Read    = (r_state == ST_REQ) || (r_state == ST_DISCARD);
  assign InstMem_Address = r_reqAddr;
  assign IF_Instruction  = w_offer ? w_offerInstr : 32'd0;
  assign IF_PC           = r_pc;
  assign IF_PCAdd4       = w_pcPlus4;
  assign IF_IsBDS        = ID_IsBranch && !r_excSeen;
  assign IF_Stall        = !w_offer;

endmodule
